// File: rtl/mips_debug_ctrl_if.sv
// rtl/mips_debug_ctrl_if.sv - byte UART handshake bundle between the UART and the debug controller
interface mips_debug_ctrl_if #(
  parameter int NBIT_DATA_LEN = 8
);
  logic                     rx_done_tick;
  logic [NBIT_DATA_LEN-1:0] rx_data_in;
  logic                     tx_done_tick;
  logic                     tx_start;
  logic [NBIT_DATA_LEN-1:0] data_out;

  modport master (
    output rx_done_tick, rx_data_in, tx_done_tick,
    input  tx_start, data_out
  );

  modport slave (
    input  rx_done_tick, rx_data_in, tx_done_tick,
    output tx_start, data_out
  );
endinterface

// File: rtl/mips_debug_ctrl.sv
// rtl/mips_debug_ctrl.sv - UART debug controller: program download, MIPS clock gating, debug snapshot dump
module mips_debug_ctrl #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int len_data       = 32,
  parameter int len_addr       = 7,
  parameter int NUM_DUMP_WORDS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  mips_debug_ctrl_if.slave                   uart,
  input  logic                               halt,
  input  logic [NUM_DUMP_WORDS*len_data-1:0] dump_bus,
  output logic [len_addr-1:0]                addr_mem_inst,
  output logic [len_data-1:0]                ins_to_mem,
  output logic                               wr_ram_inst,
  output logic                               ctrl_clk_mips,
  output logic                               reset_mips,
  output logic                               debug,
  output logic [2:0]                         state_out
);
  localparam int BPW    = len_data / NBIT_DATA_LEN;
  localparam int DUMP_W = NUM_DUMP_WORDS * len_data;
  localparam int NBYTES = NUM_DUMP_WORDS * BPW;
  localparam int TXW    = $clog2(NBYTES + 1);
  localparam int BCW    = $clog2(BPW + 1);
  localparam int CW     = NBIT_DATA_LEN + 1;
  localparam int DEPTH  = 2 ** len_addr;

  localparam logic [NBIT_DATA_LEN-1:0] CMD_LOAD  = NBIT_DATA_LEN'(8'h01);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_RUN   = NBIT_DATA_LEN'(8'h02);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_STEP  = NBIT_DATA_LEN'(8'h03);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_RST   = NBIT_DATA_LEN'(8'h05);
  localparam logic [NBIT_DATA_LEN-1:0] REPLY_OK  = NBIT_DATA_LEN'(8'hA5);
  localparam logic [NBIT_DATA_LEN-1:0] REPLY_ERR = NBIT_DATA_LEN'(8'hEE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LCNT   = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    STEP   = 3'd4,
    SNAP   = 3'd5,
    SEND   = 3'd6,
    WAITTX = 3'd7
  } state_t;

  state_t             state, state_n;
  logic [DUMP_W-1:0]  snap;
  logic [len_data-1:0] shreg;
  logic [len_data-1:0] word_n;
  logic [BCW-1:0]     byte_cnt;
  logic [CW-1:0]      word_idx;
  logic [CW-1:0]      load_n;
  logic [TXW-1:0]     tx_idx;
  logic [TXW-1:0]     tx_total;
  logic               last_byte, last_word, in_range, tx_last;

  // Word k of the snapshot occupies bits [k*len_data +: len_data]; bytes leave MSB first.
  function automatic logic [NBIT_DATA_LEN-1:0] pick(input logic [DUMP_W-1:0] v, input int idx);
    int pos;
    pos = (idx / BPW) * len_data + (BPW - 1 - (idx % BPW)) * NBIT_DATA_LEN;
    return NBIT_DATA_LEN'(v >> pos);
  endfunction

  assign state_out = state;
  assign word_n    = len_data'({shreg, uart.rx_data_in});
  assign last_byte = (byte_cnt == BCW'(BPW - 1));
  assign last_word = ((word_idx + CW'(1)) == load_n);
  assign in_range  = (32'(word_idx) < 32'(DEPTH));
  assign tx_last   = ((tx_idx + TXW'(1)) == tx_total);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ctrl_clk_mips = 1'b0;
    uart.tx_start = 1'b0;
    case (state)
      IDLE: begin
        if (uart.rx_done_tick) begin
          case (uart.rx_data_in)
            CMD_LOAD: state_n = LCNT;
            CMD_RUN:  state_n = halt ? SNAP : RUN;
            CMD_STEP: state_n = halt ? SNAP : STEP;
            default:  state_n = SEND;
          endcase
        end
      end
      LCNT: if (uart.rx_done_tick) state_n = LOAD;
      LOAD: if (uart.rx_done_tick && last_byte && last_word) state_n = SEND;
      RUN: begin
        ctrl_clk_mips = 1'b1;
        if (halt || uart.rx_done_tick) state_n = SNAP;
      end
      STEP: begin
        ctrl_clk_mips = 1'b1;
        state_n       = SNAP;
      end
      SNAP: state_n = SEND;
      SEND: begin
        uart.tx_start = 1'b1;
        state_n       = WAITTX;
      end
      WAITTX: if (uart.tx_done_tick) state_n = tx_last ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap          <= '0;
      shreg         <= '0;
      byte_cnt      <= '0;
      word_idx      <= '0;
      load_n        <= '0;
      tx_idx        <= '0;
      tx_total      <= '0;
      uart.data_out <= '0;
      addr_mem_inst <= '0;
      ins_to_mem    <= '0;
      wr_ram_inst   <= 1'b0;
      reset_mips    <= 1'b0;
      debug         <= 1'b0;
    end else begin
      wr_ram_inst <= 1'b0;
      reset_mips  <= 1'b0;
      case (state)
        IDLE: begin
          if (uart.rx_done_tick) begin
            tx_idx   <= '0;
            tx_total <= TXW'(1);
            case (uart.rx_data_in)
              CMD_LOAD: ;
              CMD_RUN:  debug <= 1'b0;
              CMD_STEP: debug <= 1'b1;
              CMD_RST: begin
                reset_mips    <= 1'b1;
                uart.data_out <= REPLY_OK;
              end
              default: uart.data_out <= REPLY_ERR;
            endcase
          end
        end
        LCNT: begin
          if (uart.rx_done_tick) begin
            load_n   <= (uart.rx_data_in == '0) ? CW'(2 ** NBIT_DATA_LEN) : CW'(uart.rx_data_in);
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          if (uart.rx_done_tick) begin
            shreg <= word_n;
            if (last_byte) begin
              byte_cnt <= '0;
              word_idx <= word_idx + CW'(1);
              // Words past the RAM depth are drained from the UART but never written.
              if (in_range) begin
                wr_ram_inst   <= 1'b1;
                ins_to_mem    <= word_n;
                addr_mem_inst <= len_addr'(word_idx);
              end
              if (last_word) begin
                uart.data_out <= REPLY_OK;
                tx_idx        <= '0;
                tx_total      <= TXW'(1);
              end
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        SNAP: begin
          snap          <= dump_bus;
          uart.data_out <= pick(dump_bus, 0);
          tx_idx        <= '0;
          tx_total      <= TXW'(NBYTES);
        end
        WAITTX: begin
          if (uart.tx_done_tick && !tx_last) begin
            tx_idx        <= tx_idx + TXW'(1);
            uart.data_out <= pick(snap, int'(tx_idx) + 1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb/tb_mips_debug_ctrl.sv - randomized self-checking bench for mips_debug_ctrl against a byte/word reference model
module tb_mips_debug_ctrl;
  localparam int NB = 8, LD = 32, NW = 4, BPW = LD / NB, NBYTES = NW * BPW;

  logic clk = 1'b0, reset = 1'b1, halt = 1'b0;
  logic [NW*LD-1:0] dump_bus = '0;

  mips_debug_ctrl_if #(.NBIT_DATA_LEN(NB)) u0 ();
  mips_debug_ctrl_if #(.NBIT_DATA_LEN(NB)) u1 ();

  logic [6:0] addr0;  logic [LD-1:0] ins0;  logic wr0, ctrl0, rstm0, dbg0;  logic [2:0] st0;
  logic [1:0] addr1;  logic [LD-1:0] ins1;  logic wr1, ctrl1, rstm1, dbg1;  logic [2:0] st1;

  always #5 clk = ~clk;

  mips_debug_ctrl #(.NBIT_DATA_LEN(NB), .len_data(LD), .len_addr(7), .NUM_DUMP_WORDS(NW)) dut0 (
    .clk(clk), .reset(reset), .uart(u0.slave), .halt(halt), .dump_bus(dump_bus),
    .addr_mem_inst(addr0), .ins_to_mem(ins0), .wr_ram_inst(wr0), .ctrl_clk_mips(ctrl0),
    .reset_mips(rstm0), .debug(dbg0), .state_out(st0));

  mips_debug_ctrl #(.NBIT_DATA_LEN(NB), .len_data(LD), .len_addr(2), .NUM_DUMP_WORDS(NW)) dut1 (
    .clk(clk), .reset(reset), .uart(u1.slave), .halt(1'b0), .dump_bus(dump_bus),
    .addr_mem_inst(addr1), .ins_to_mem(ins1), .wr_ram_inst(wr1), .ctrl_clk_mips(ctrl1),
    .reset_mips(rstm1), .debug(dbg1), .state_out(st1));

  int checks = 0, errors = 0;

  // Observed traffic, appended by the monitor only.
  logic [7:0]  txq0[$], txq1[$];
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int clkcnt0 = 0, rstcnt0 = 0;

  // Expected traffic for the step in progress.
  logic [7:0]  etx[$];
  logic [31:0] ea[$], ed[$];
  int rdt[2] = '{0, 0};
  int rdw[2] = '{0, 0};

  always @(negedge clk) begin
    if (u0.tx_start) txq0.push_back(u0.data_out);
    if (u1.tx_start) txq1.push_back(u1.data_out);
    if (wr0) begin wa0.push_back(32'(addr0)); wd0.push_back(ins0); end
    if (wr1) begin wa1.push_back(32'(addr1)); wd1.push_back(ins1); end
    if (ctrl0) clkcnt0++;
    if (rstm0) rstcnt0++;
  end

  initial begin
    u0.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (u0.tx_start) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 u0.tx_done_tick = 1'b1;
        @(posedge clk);
        #1 u0.tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    u1.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (u1.tx_start) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 u1.tx_done_tick = 1'b1;
        @(posedge clk);
        #1 u1.tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tx_size(input int sel);
    return (sel == 0) ? txq0.size() : txq1.size();
  endfunction

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin u0.rx_data_in = b; u0.rx_done_tick = 1'b1; end
    else          begin u1.rx_data_in = b; u1.rx_done_tick = 1'b1; end
    @(posedge clk); #1;
    u0.rx_done_tick = 1'b0;
    u1.rx_done_tick = 1'b0;
  endtask

  task automatic expect_dump(input logic [NW*LD-1:0] bus);
    for (int w = 0; w < NW; w++)
      for (int b = BPW - 1; b >= 0; b--)
        etx.push_back(8'(bus >> (w * LD + b * NB)));
  endtask

  task automatic load_words(input int sel, input logic [31:0] ws[$], input int depth);
    send_byte(sel, 8'h01);
    send_byte(sel, 8'(ws.size()));
    for (int i = 0; i < ws.size(); i++) begin
      if (i < depth) begin ea.push_back(32'(i)); ed.push_back(ws[i]); end
      for (int b = BPW - 1; b >= 0; b--) send_byte(sel, 8'(ws[i] >> (8 * b)));
    end
    etx.push_back(8'hA5);
  endtask

  task automatic load_rand(input int sel, input int n, input int depth);
    logic [31:0] ws[$];
    for (int i = 0; i < n; i++) ws.push_back($urandom);
    load_words(sel, ws, depth);
  endtask

  // Wait for the expected replies and a return to IDLE, then compare everything seen since the last step.
  task automatic finish_step(input int sel, input string tag);
    int cyc;
    logic [2:0] st;
    logic [7:0]  tq[$];
    logic [31:0] aq[$], dq[$];
    int nt, nw;
    cyc = 0;
    st = (sel == 0) ? st0 : st1;
    while (cyc < 4000 && !(tx_size(sel) >= rdt[sel] + etx.size() && st == 3'd0)) begin
      @(posedge clk); #1;
      st = (sel == 0) ? st0 : st1;
      cyc++;
    end
    repeat (8) @(posedge clk);
    #1;
    st = (sel == 0) ? st0 : st1;
    check($sformatf("%s idle", tag), 64'(st), 64'd0);
    if (sel == 0) begin tq = txq0; aq = wa0; dq = wd0; end
    else          begin tq = txq1; aq = wa1; dq = wd1; end
    nt = tq.size() - rdt[sel];
    nw = aq.size() - rdw[sel];
    check($sformatf("%s tx_count", tag), 64'(nt), 64'(etx.size()));
    for (int i = 0; i < nt && i < etx.size(); i++)
      check($sformatf("%s tx%0d", tag, i), 64'(tq[rdt[sel] + i]), 64'(etx[i]));
    check($sformatf("%s wr_count", tag), 64'(nw), 64'(ea.size()));
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      check($sformatf("%s wr_addr%0d", tag, i), 64'(aq[rdw[sel] + i]), 64'(ea[i]));
      check($sformatf("%s wr_data%0d", tag, i), 64'(dq[rdw[sel] + i]), 64'(ed[i]));
    end
    rdt[sel] = tq.size();
    rdw[sel] = aq.size();
    etx.delete(); ea.delete(); ed.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 64'(st0), 64'd0);
    check({tag, " wr"}, 64'(wr0), 64'd0);
    check({tag, " ctrl_clk"}, 64'(ctrl0), 64'd0);
    check({tag, " reset_mips"}, 64'(rstm0), 64'd0);
    check({tag, " debug"}, 64'(dbg0), 64'd0);
    check({tag, " tx_start"}, 64'(u0.tx_start), 64'd0);
    check({tag, " data_out"}, 64'(u0.data_out), 64'd0);
    check({tag, " addr"}, 64'(addr0), 64'd0);
    check({tag, " ins"}, 64'(ins0), 64'd0);
  endtask

  initial begin
    logic [31:0] ws[$];
    logic [NW*LD-1:0] bus;
    logic [7:0] b;
    int c0, r0, k;

    u0.rx_done_tick = 1'b0; u0.rx_data_in = '0;
    u1.rx_done_tick = 1'b0; u1.rx_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    ws = '{32'h0000002A, 32'h12345678};
    load_words(0, ws, 128);
    finish_step(0, "load_dir");

    repeat (3) begin
      load_rand(0, $urandom_range(1, 5), 128);
      finish_step(0, "load_rand");
    end

    // Free run halted after 50 cycles; dump_bus changes once sending has begun.
    bus = {$urandom, $urandom, $urandom, $urandom};
    dump_bus = bus;
    expect_dump(bus);
    c0 = clkcnt0;
    send_byte(0, 8'h02);
    repeat (49) @(posedge clk);
    #1 halt = 1'b1;
    k = 0;
    while (txq0.size() <= rdt[0] && k < 200) begin @(posedge clk); #1; k++; end
    dump_bus = {$urandom, $urandom, $urandom, $urandom};
    finish_step(0, "run_halt");
    check("run_halt clk_cycles", 64'(clkcnt0 - c0), 64'd50);
    check("run_halt debug", 64'(dbg0), 64'd0);
    halt = 1'b0;

    // Unknown commands and MIPS reset.
    send_byte(0, 8'h7F);
    etx.push_back(8'hEE);
    finish_step(0, "unknown_7f");
    repeat (3) begin
      b = 8'($urandom);
      if (b == 8'h01 || b == 8'h02 || b == 8'h03 || b == 8'h05) b = 8'h7F;
      send_byte(0, b);
      etx.push_back(8'hEE);
      finish_step(0, "unknown_rand");
    end
    r0 = rstcnt0;
    send_byte(0, 8'h05);
    etx.push_back(8'hA5);
    finish_step(0, "rst_cmd");
    check("rst_cmd pulses", 64'(rstcnt0 - r0), 64'd1);

    // Abort a free run with an arbitrary byte after k cycles.
    repeat (2) begin
      k = $urandom_range(5, 40);
      bus = {$urandom, $urandom, $urandom, $urandom};
      dump_bus = bus;
      expect_dump(bus);
      c0 = clkcnt0;
      send_byte(0, 8'h02);
      repeat (k - 2) @(posedge clk);
      send_byte(0, 8'($urandom));
      finish_step(0, "run_abort");
      check("run_abort clk_cycles", 64'(clkcnt0 - c0), 64'(k));
    end

    // Halt already high: RUN goes straight to the snapshot.
    halt = 1'b1;
    bus = {$urandom, $urandom, $urandom, $urandom};
    dump_bus = bus;
    expect_dump(bus);
    c0 = clkcnt0;
    send_byte(0, 8'h02);
    finish_step(0, "run_halted");
    check("run_halted clk_cycles", 64'(clkcnt0 - c0), 64'd0);
    halt = 1'b0;

    // Single step then RUN clears debug.
    bus = {$urandom, $urandom, $urandom, $urandom};
    dump_bus = bus;
    expect_dump(bus);
    c0 = clkcnt0;
    send_byte(0, 8'h03);
    finish_step(0, "step");
    check("step clk_cycles", 64'(clkcnt0 - c0), 64'd1);
    check("step debug", 64'(dbg0), 64'd1);
    halt = 1'b1;
    expect_dump(dump_bus);
    send_byte(0, 8'h02);
    finish_step(0, "run_after_step");
    check("run_after_step debug", 64'(dbg0), 64'd0);
    halt = 1'b0;

    // Overflow on a 4-word RAM.
    load_rand(1, 6, 4);
    finish_step(1, "overflow");

    // Reset during a partial word, with debug set beforehand.
    halt = 1'b1;
    expect_dump(dump_bus);
    send_byte(0, 8'h03);
    finish_step(0, "step_pre_reset");
    halt = 1'b0;
    send_byte(0, 8'h01);
    send_byte(0, 8'h01);
    send_byte(0, 8'hDE);
    send_byte(0, 8'hAD);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    finish_step(0, "after_reset");
    load_rand(0, 1, 128);
    finish_step(0, "load_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
